// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: Moore decode of RUN/STALL/FLUSH into PC and IF/ID/ID-EX controls.
// Optional stall watchdog enabled by defining STALL_WATCHDOG_EN.
module pipe_stall_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_MAX    = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_req,
  input  logic        mispredict,
  input  logic [15:0] branch_target,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pc_redirect,
  output logic [15:0] redirect_pc,
  output logic [1:0]  state,
  output logic [7:0]  mp_count,
  output logic        stall_timeout
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || STALL_MAX < 1 || STALL_MAX > 255) begin : g_badParams
    $error("pipe_stall_ctrl: FLUSH_CYCLES or STALL_MAX out of range");
  end

  logic [1:0]  r_state;
  logic [2:0]  r_flushCnt;
  logic [15:0] r_redirectPc;
  logic        r_pcRedirect;
  logic [7:0]  r_mpCount;
  logic        w_takeFlush;
  logic        w_watchdogFire;

  // Encoding 3 is unreachable; it ignores mispredict and simply falls back to RUN.
  assign w_takeFlush = mispredict && (r_state != 2'd3);

`ifdef STALL_WATCHDOG_EN
  localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX - 1);
  logic [7:0] r_stallCnt;
  logic       r_stallTimeout;

  assign w_watchdogFire = (r_state == ST_STALL) && stall_req && !mispredict
                          && (r_stallCnt == STALL_LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stallCnt     <= 8'd0;
      r_stallTimeout <= 1'b0;
    end else begin
      if (r_state != ST_STALL)
        r_stallCnt <= 8'd0;
      else if (stall_req && !mispredict)
        r_stallCnt <= r_stallCnt + 8'd1;
      if (w_watchdogFire)
        r_stallTimeout <= 1'b1;
    end
  end

  assign stall_timeout = r_stallTimeout;
`else
  assign w_watchdogFire = 1'b0;
  assign stall_timeout  = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_flushCnt   <= 3'd0;
      r_redirectPc <= 16'd0;
      r_pcRedirect <= 1'b0;
      r_mpCount    <= 8'd0;
    end else begin
      r_pcRedirect <= 1'b0;
      if (w_takeFlush) begin
        // Entry into FLUSH and restart within FLUSH share the same capture path.
        r_state      <= ST_FLUSH;
        r_flushCnt   <= FLUSH_LOAD;
        r_redirectPc <= branch_target;
        r_pcRedirect <= 1'b1;
        if (r_mpCount != 8'hFF)
          r_mpCount <= r_mpCount + 8'd1;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (stall_req)
              r_state <= ST_STALL;
          end
          ST_STALL: begin
            if (!stall_req || w_watchdogFire)
              r_state <= ST_RUN;
          end
          ST_FLUSH: begin
            if (r_flushCnt <= 3'd1) begin
              r_state    <= ST_RUN;
              r_flushCnt <= 3'd0;
            end else begin
              r_flushCnt <= r_flushCnt - 3'd1;
            end
          end
          default: r_state <= ST_RUN;
        endcase
      end
    end
  end

  // Reset holds the PC and IF/ID registers regardless of the registered state.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_RUN: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
        ST_STALL: begin
          idex_bubble = 1'b1;
        end
        ST_FLUSH: begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        default: begin
          idex_bubble = 1'b1;
        end
      endcase
    end
  end

  assign pc_redirect = r_pcRedirect;
  assign redirect_pc = r_redirectPc;
  assign state       = r_state;
  assign mp_count    = r_mpCount;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table through a scoreboard queue,
// plus hand-written watchdog, saturation and mid-operation reset sequences.
module tb_pipe_stall_ctrl;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
`ifdef STALL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_req;
  logic        mispredict;
  logic [15:0] branch_target;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, pc_redirect, stall_timeout;
  logic [15:0] redirect_pc;
  logic [1:0]  state;
  logic [7:0]  mp_count;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic        sr;
    logic        mp;
    logic [15:0] tgt;
    logic [1:0]  st;
    logic        redir;
    logic [15:0] rpc;
    logic [7:0]  mpc;
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    logic        redir;
    logic [15:0] rpc;
    logic [7:0]  mpc;
  } exp_t;

  vec_t vecs[$];
  exp_t sbQ[$];

  pipe_stall_ctrl #(.FLUSH_CYCLES(2), .STALL_MAX(15)) dut (
    .clock(clock), .reset(reset), .stall_req(stall_req), .mispredict(mispredict),
    .branch_target(branch_target), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .state(state), .mp_count(mp_count),
    .stall_timeout(stall_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time budget");
    $fatal(1, "[TB] time budget expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected control outputs come from the documented per-state decode table.
  task automatic checkDecode(input string tag, input logic [1:0] st);
    checkVal({tag, " state"},       state,       st);
    checkVal({tag, " pc_write"},    pc_write,    st != STALL);
    checkVal({tag, " ifid_write"},  ifid_write,  st != STALL);
    checkVal({tag, " ifid_flush"},  ifid_flush,  st == FLUSH);
    checkVal({tag, " idex_bubble"}, idex_bubble, st != RUN);
  endtask

  task automatic addVec(input logic sr, input logic mp, input logic [15:0] tgt,
                        input logic [1:0] st, input logic redir,
                        input logic [15:0] rpc, input logic [7:0] mpc);
    vec_t v;
    v.sr = sr; v.mp = mp; v.tgt = tgt; v.st = st; v.redir = redir; v.rpc = rpc; v.mpc = mpc;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    stall_req     = v.sr;
    mispredict    = v.mp;
    branch_target = v.tgt;
    e.st = v.st; e.redir = v.redir; e.rpc = v.rpc; e.mpc = v.mpc;
    sbQ.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sbQ.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s scoreboard: queue empty, got 1 expected 0", tag);
    end else begin
      e = sbQ.pop_front();
      checkDecode(tag, e.st);
      checkVal({tag, " pc_redirect"}, pc_redirect, e.redir);
      checkVal({tag, " redirect_pc"}, redirect_pc, e.rpc);
      checkVal({tag, " mp_count"},    mp_count,    e.mpc);
    end
  endtask

  task automatic step(input logic sr, input logic mp, input logic [15:0] tgt);
    stall_req = sr; mispredict = mp; branch_target = tgt;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_req = 1'b0; mispredict = 1'b0; branch_target = 16'h0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkVal("reset pc_write",    pc_write,    1'b0);
    checkVal("reset ifid_write",  ifid_write,  1'b0);
    checkVal("reset state",       state,       RUN);
    checkVal("reset mp_count",    mp_count,    8'd0);
    checkVal("reset redirect_pc", redirect_pc, 16'h0);
    checkVal("reset pc_redirect", pc_redirect, 1'b0);
    checkVal("reset timeout",     stall_timeout, 1'b0);
    reset = 1'b0;
    #1;
    checkDecode("after reset", RUN);

    // Stall for 3 cycles, then a simple mispredict, a simultaneous stall+mispredict,
    // a restart in the 2nd flush cycle and a mispredict taken from STALL.
    addVec(1, 0, 16'h0000, STALL, 0, 16'h0000, 8'd0);
    addVec(1, 0, 16'h0000, STALL, 0, 16'h0000, 8'd0);
    addVec(1, 0, 16'h0000, STALL, 0, 16'h0000, 8'd0);
    addVec(0, 0, 16'h0000, RUN,   0, 16'h0000, 8'd0);
    addVec(0, 1, 16'h0040, FLUSH, 1, 16'h0040, 8'd1);
    addVec(0, 0, 16'h0000, FLUSH, 0, 16'h0040, 8'd1);
    addVec(0, 0, 16'h0000, RUN,   0, 16'h0040, 8'd1);
    addVec(1, 1, 16'h1234, FLUSH, 1, 16'h1234, 8'd2);
    addVec(1, 0, 16'h0000, FLUSH, 0, 16'h1234, 8'd2);
    addVec(0, 0, 16'h0000, RUN,   0, 16'h1234, 8'd2);
    addVec(0, 1, 16'h0100, FLUSH, 1, 16'h0100, 8'd3);
    addVec(0, 0, 16'h0000, FLUSH, 0, 16'h0100, 8'd3);
    addVec(0, 1, 16'h0080, FLUSH, 1, 16'h0080, 8'd4);
    addVec(0, 0, 16'h0000, FLUSH, 0, 16'h0080, 8'd4);
    addVec(0, 0, 16'h0000, RUN,   0, 16'h0080, 8'd4);
    addVec(1, 0, 16'h0000, STALL, 0, 16'h0080, 8'd4);
    addVec(1, 1, 16'h00AA, FLUSH, 1, 16'h00AA, 8'd5);
    addVec(1, 0, 16'h0000, FLUSH, 0, 16'h00AA, 8'd5);
    addVec(0, 0, 16'h0000, RUN,   0, 16'h00AA, 8'd5);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // Stall held high: the watchdog build releases after 15 STALL cycles.
    doReset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 16'h0);
      checkVal($sformatf("wd cycle%0d state", i), state,
               (WD && i == 16) ? RUN : STALL);
    end
    checkVal("wd timeout", stall_timeout, WD);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    checkVal("wd timeout sticky", stall_timeout, WD);
    checkVal("wd back to run", state, RUN);

    // 260 separated mispredicts saturate the counter at 255.
    doReset();
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 1'b1, 16'(i));
      step(1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b0, 16'h0);
      if (i == 254) checkVal("mp_count at 255", mp_count, 8'd255);
    end
    checkVal("mp_count saturated", mp_count, 8'd255);
    checkVal("last redirect_pc", redirect_pc, 16'd259);

    // Reset overriding a flush in progress.
    step(1'b0, 1'b1, 16'hBEEF);
    checkVal("pre-reset state", state, FLUSH);
    reset = 1'b1;
    step(1'b1, 1'b1, 16'h5555);
    checkVal("flush reset state",       state,       RUN);
    checkVal("flush reset mp_count",    mp_count,    8'd0);
    checkVal("flush reset pc_redirect", pc_redirect, 1'b0);
    checkVal("flush reset redirect_pc", redirect_pc, 16'h0);
    checkVal("flush reset pc_write",    pc_write,    1'b0);
    checkVal("flush reset ifid_write",  ifid_write,  1'b0);

    // Reset overriding a stall in progress.
    reset = 1'b0;
    step(1'b1, 1'b0, 16'h0);
    checkVal("pre-reset stall", state, STALL);
    reset = 1'b1;
    step(1'b1, 1'b0, 16'h0);
    checkVal("stall reset state", state, RUN);
    reset = 1'b0;
    step(1'b0, 1'b0, 16'h0);
    checkDecode("post reset run", RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
